dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the dmem request/done protocol driven by the load/store read-write unit.
- Accepts single-cycle read or write request pulses and holds one request outstanding at a time.
- Completes each request after a fixed, parameterised latency with a one-cycle done pulse; reads return data on the same cycle.
- Used as the synthesizable data RAM in the core top and as the memory model in core-level benches.

---
 rtl/dmem_responder_if.sv | 19 +
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/done bus between the load/store unit (master) and data memory (slave).
interface dmem_responder_if;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_data;
   logic [31:0] dmem_rd_data;
   logic        dmem_done;
   logic        dmem_err;
   logic        dmem_busy;
   modport master (
      output dmem_read, dmem_write, dmem_addr, dmem_data,
      input  dmem_rd_data, dmem_done, dmem_err, dmem_busy
   );
   modport slave (
      input  dmem_read, dmem_write, dmem_addr, dmem_data,
      output dmem_rd_data, dmem_done, dmem_err, dmem_busy
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data RAM answering one outstanding read/write request with a done pulse.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic             clk_i,
   input logic             reset_i,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic          l_write;
   logic          l_err;
   logic [AW-1:0] l_idx;
   logic [31:0]   l_data;
   logic          done;
   logic          err;
   logic          busy;
   logic [31:0]   rd_data;
   logic [31:0]   mem [DEPTH_WORDS];
   logic          req;
   logic          req_err;
   logic [AW-1:0] req_idx;
   logic          commit;
   logic          fin_write;
   logic          fin_err;
   logic [AW-1:0] fin_idx;
   logic          fwd;
   logic [31:0]   fin_data;
   assign req     = state != BUSY && (bus.dmem_read || bus.dmem_write);
   assign req_idx = bus.dmem_addr[AW+1:2];
   assign req_err = bus.dmem_addr[1:0] != 2'b00
                 || (bus.dmem_addr >> (AW + 2)) != 32'd0
                 || (bus.dmem_read && bus.dmem_write);
   assign commit  = state == RESP && l_write && !l_err;
   // The request entering its done cycle at the next edge: latched one from BUSY, else the incoming one.
   assign fin_write = state == BUSY ? l_write : bus.dmem_write;
   assign fin_err   = state == BUSY ? l_err   : req_err;
   assign fin_idx   = state == BUSY ? l_idx   : req_idx;
   // A write committing at this same edge must be visible to the read being registered now.
   assign fwd      = commit && l_idx == fin_idx;
   assign fin_data = (fin_err || fin_write) ? 32'd0 : fwd ? l_data : mem[fin_idx];
   always_ff @(posedge clk_i)
      if (commit) mem[l_idx] <= l_data;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= IDLE;
         cnt     <= '0;
         l_write <= 1'b0;
         l_err   <= 1'b0;
         l_idx   <= '0;
         l_data  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         rd_data <= '0;
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         rd_data <= '0;
         if (req) begin
            l_write <= bus.dmem_write;
            l_err   <= req_err;
            l_idx   <= req_idx;
            l_data  <= bus.dmem_data;
            if (LATENCY == 1) begin
               state   <= RESP;
               done    <= 1'b1;
               err     <= fin_err;
               rd_data <= fin_data;
            end else begin
               state <= BUSY;
               cnt   <= CNT_INIT;
               busy  <= 1'b1;
            end
         end else if (state == BUSY) begin
            if (cnt == '0) begin
               state   <= RESP;
               done    <= 1'b1;
               err     <= fin_err;
               rd_data <= fin_data;
            end else begin
               cnt  <= cnt - 1'b1;
               busy <= 1'b1;
            end
         end else begin
            state <= IDLE;
         end
      end
   end
   assign bus.dmem_done    = done;
   assign bus.dmem_err     = err;
   assign bus.dmem_busy    = busy;
   assign bus.dmem_rd_data = rd_data;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responder instances (LATENCY 2, 1 and 3).
module tb_dmem_responder;
   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   int   pass = 0;
   int   total = 0;
   always #5 clk_i = ~clk_i;
   dmem_responder_if ia ();
   dmem_responder_if ib ();
   dmem_responder_if ic ();
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (.clk_i(clk_i), .reset_i(reset_i), .bus(ia.slave));
   dmem_responder #(.DEPTH_WORDS(16),   .LATENCY(1)) dut_b (.clk_i(clk_i), .reset_i(reset_i), .bus(ib.slave));
   dmem_responder #(.DEPTH_WORDS(64),   .LATENCY(3)) dut_c (.clk_i(clk_i), .reset_i(reset_i), .bus(ic.slave));

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input int d, input logic r, input logic w, input logic [31:0] ad, input logic [31:0] dt);
      if (d == 0) begin
         ia.dmem_read = r; ia.dmem_write = w; ia.dmem_addr = ad; ia.dmem_data = dt;
      end else if (d == 1) begin
         ib.dmem_read = r; ib.dmem_write = w; ib.dmem_addr = ad; ib.dmem_data = dt;
      end else begin
         ic.dmem_read = r; ic.dmem_write = w; ic.dmem_addr = ad; ic.dmem_data = dt;
      end
   endtask

   task automatic sample(input int d, output logic dn, output logic er, output logic bs, output logic [31:0] rd);
      dn = d == 0 ? ia.dmem_done    : d == 1 ? ib.dmem_done    : ic.dmem_done;
      er = d == 0 ? ia.dmem_err     : d == 1 ? ib.dmem_err     : ic.dmem_err;
      bs = d == 0 ? ia.dmem_busy    : d == 1 ? ib.dmem_busy    : ic.dmem_busy;
      rd = d == 0 ? ia.dmem_rd_data : d == 1 ? ib.dmem_rd_data : ic.dmem_rd_data;
   endtask

   // One-cycle request, then wait (bounded) for done; returns cycles to done or -1, ending in the done cycle.
   task automatic xact(input int d, input logic r, input logic w, input logic [31:0] ad, input logic [31:0] dt,
                       output int lat, output logic er, output logic [31:0] rd);
      logic dn, bs;
      drive(d, r, w, ad, dt);
      tick();
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
      lat = -1;
      er  = 1'b0;
      rd  = 32'd0;
      for (int i = 1; i <= 10; i++) begin
         sample(d, dn, er, bs, rd);
         if (dn) begin
            lat = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
      reset_i = 1'b1;
      #1;
      total++;
      if ({ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data, ib.dmem_done, ib.dmem_err, ib.dmem_busy,
           ib.dmem_rd_data, ic.dmem_done, ic.dmem_err, ic.dmem_busy, ic.dmem_rd_data} !== 105'd0)
         $display("FAIL reset_outputs: got a=%b%b%b/%h b=%b%b%b/%h c=%b%b%b/%h, want all 0",
                  ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data, ib.dmem_done, ib.dmem_err,
                  ib.dmem_busy, ib.dmem_rd_data, ic.dmem_done, ic.dmem_err, ic.dmem_busy, ic.dmem_rd_data);
      else pass++;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
      tick();
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      total++;
      if (ia.dmem_busy !== 1'b1) $display("FAIL pre_reset_busy: got %b, want 1", ia.dmem_busy);
      else pass++;
      #2 reset_i = 1'b1;
      #1;
      total++;
      if ({ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data} !== 35'd0)
         $display("FAIL async_reset: got done=%b err=%b busy=%b rd=%h, want 0 0 0 0",
                  ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data);
      else pass++;
      #1 reset_i = 1'b0;
      tick();
      tick();
      total++;
      if (ia.dmem_done !== 1'b0) $display("FAIL reset_no_done: got done=%b, want 0", ia.dmem_done);
      else pass++;
   endtask

   task automatic test_write_read;
      tick();
      drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      tick();
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      total++;
      if ({ia.dmem_busy, ia.dmem_done} !== 2'b10)
         $display("FAIL wr_cycle1: got busy=%b done=%b, want 1 0", ia.dmem_busy, ia.dmem_done);
      else pass++;
      tick();
      total++;
      if ({ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data} !== {3'b100, 32'd0})
         $display("FAIL wr_done: got done=%b err=%b busy=%b rd=%h, want 1 0 0 00000000",
                  ia.dmem_done, ia.dmem_err, ia.dmem_busy, ia.dmem_rd_data);
      else pass++;
      tick();
      total++;
      if (ia.dmem_done !== 1'b0) $display("FAIL wr_pulse: got done=%b in cycle 3, want 0", ia.dmem_done);
      else pass++;
      drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
      tick();
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      total++;
      if ({ia.dmem_done, ia.dmem_err, ia.dmem_rd_data} !== {2'b10, 32'hDEADBEEF})
         $display("FAIL rd_done: got done=%b err=%b rd=%h, want 1 0 deadbeef",
                  ia.dmem_done, ia.dmem_err, ia.dmem_rd_data);
      else pass++;
      tick();
      total++;
      if ({ia.dmem_done, ia.dmem_rd_data} !== 33'd0)
         $display("FAIL rd_after: got done=%b rd=%h, want 0 00000000", ia.dmem_done, ia.dmem_rd_data);
      else pass++;
   endtask

   task automatic test_back_to_back;
      tick();
      drive(1, 1'b0, 1'b1, 32'h20, 32'h12345678);
      tick();
      total++;
      if ({ib.dmem_done, ib.dmem_err, ib.dmem_busy, ib.dmem_rd_data} !== {3'b100, 32'd0})
         $display("FAIL b2b_wr_done: got done=%b err=%b busy=%b rd=%h, want 1 0 0 00000000",
                  ib.dmem_done, ib.dmem_err, ib.dmem_busy, ib.dmem_rd_data);
      else pass++;
      drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
      tick();
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      total++;
      if ({ib.dmem_done, ib.dmem_err, ib.dmem_busy, ib.dmem_rd_data} !== {3'b100, 32'h12345678})
         $display("FAIL b2b_rd_done: got done=%b err=%b busy=%b rd=%h, want 1 0 0 12345678",
                  ib.dmem_done, ib.dmem_err, ib.dmem_busy, ib.dmem_rd_data);
      else pass++;
      tick();
      total++;
      if (ib.dmem_done !== 1'b0) $display("FAIL b2b_idle: got done=%b, want 0", ib.dmem_done);
      else pass++;
   endtask

   task automatic test_errors;
      int lat;
      logic er;
      logic [31:0] rd;
      tick();
      xact(0, 1'b0, 1'b1, 32'h0, 32'h0BADCAFE, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b0) $display("FAIL err_wr0: got lat=%0d err=%b, want 2 0", lat, er);
      else pass++;
      xact(0, 1'b1, 1'b0, 32'h13, 32'd0, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0)
         $display("FAIL err_misaligned: got lat=%0d err=%b rd=%h, want 2 1 00000000", lat, er, rd);
      else pass++;
      xact(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0)
         $display("FAIL err_range: got lat=%0d err=%b rd=%h, want 2 1 00000000", lat, er, rd);
      else pass++;
      xact(0, 1'b1, 1'b0, 32'h0, 32'd0, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'h0BADCAFE)
         $display("FAIL err_range_noWr: got lat=%0d err=%b rd=%h, want 2 0 0badcafe", lat, er, rd);
      else pass++;
      xact(0, 1'b1, 1'b1, 32'h0, 32'h11111111, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b1 || rd !== 32'd0)
         $display("FAIL err_rw_both: got lat=%0d err=%b rd=%h, want 2 1 00000000", lat, er, rd);
      else pass++;
      xact(0, 1'b1, 1'b0, 32'h0, 32'd0, lat, er, rd);
      total++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'h0BADCAFE)
         $display("FAIL err_rw_noWr: got lat=%0d err=%b rd=%h, want 2 0 0badcafe", lat, er, rd);
      else pass++;
      tick();
      total++;
      if ({ia.dmem_done, ia.dmem_err} !== 2'b00)
         $display("FAIL err_idle: got done=%b err=%b, want 0 0", ia.dmem_done, ia.dmem_err);
      else pass++;
   endtask

   task automatic test_busy_drop;
      int lat;
      int n;
      logic er;
      logic [31:0] rd;
      tick();
      xact(2, 1'b0, 1'b1, 32'h40, 32'h55AA55AA, lat, er, rd);
      total++;
      if (lat !== 3 || er !== 1'b0) $display("FAIL l3_wr: got lat=%0d err=%b, want 3 0", lat, er);
      else pass++;
      tick();
      drive(2, 1'b1, 1'b0, 32'h40, 32'd0);
      tick();
      drive(2, 1'b1, 1'b0, 32'h44, 32'd0);
      total++;
      if ({ic.dmem_busy, ic.dmem_done} !== 2'b10)
         $display("FAIL drop_c1: got busy=%b done=%b, want 1 0", ic.dmem_busy, ic.dmem_done);
      else pass++;
      tick();
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      total++;
      if ({ic.dmem_busy, ic.dmem_done} !== 2'b10)
         $display("FAIL drop_c2: got busy=%b done=%b, want 1 0", ic.dmem_busy, ic.dmem_done);
      else pass++;
      tick();
      total++;
      if ({ic.dmem_done, ic.dmem_err, ic.dmem_busy, ic.dmem_rd_data} !== {3'b100, 32'h55AA55AA})
         $display("FAIL drop_c3: got done=%b err=%b busy=%b rd=%h, want 1 0 0 55aa55aa",
                  ic.dmem_done, ic.dmem_err, ic.dmem_busy, ic.dmem_rd_data);
      else pass++;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ic.dmem_done === 1'b1 || ic.dmem_busy === 1'b1) n++;
      end
      total++;
      if (n !== 0) $display("FAIL drop_extra: got %0d busy/done cycles after done, want 0", n);
      else pass++;
   endtask

   task automatic test_reset_midop;
      int lat;
      int n;
      logic er;
      logic [31:0] rd;
      drive(2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
      tick();
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      #2 reset_i = 1'b1;
      #2 reset_i = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ic.dmem_done === 1'b1) n++;
      end
      total++;
      if (n !== 0) $display("FAIL midop_done: got %0d done pulses, want 0", n);
      else pass++;
      xact(2, 1'b1, 1'b0, 32'h40, 32'd0, lat, er, rd);
      total++;
      if (lat !== 3 || er !== 1'b0 || rd !== 32'h55AA55AA)
         $display("FAIL midop_readback: got lat=%0d err=%b rd=%h, want 3 0 55aa55aa", lat, er, rd);
      else pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_busy_drop();
      test_reset_midop();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
